// File: rtl/unary_add_pkg.sv
// Shared types and defaults for the unary-add sequencer family.
// Holds the controller state encoding and the operand clamp used at acceptance.
package unary_add_pkg;

   localparam int N_DEF       = 16;
   localparam int OUT_LEN_DEF = 2 * N_DEF;
   localparam int DP_LAT_DEF  = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Operands above the stream length would need more ones than the stream has.
   function automatic int unsigned sat_operand(input int unsigned v, input int unsigned lim);
      if (v > lim) begin
         return lim;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/unary_stream_gen.sv
// Ones-first bitstream generator: an index counter and two comparators.
// Bits are registered so they line up with the cycle the controller sits in LOAD.
module unary_stream_gen #(
   parameter int N  = 16,
   parameter int IW = $clog2(N + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          step_i,
   input  logic [IW-1:0] a_lat_i,
   input  logic [IW-1:0] b_lat_i,
   output logic          a_bit_o,
   output logic          b_bit_o,
   output logic          last_o
);

   logic [IW-1:0] idx_q, idx_d;
   logic          a_bit_q, a_bit_d;
   logic          b_bit_q, b_bit_d;

   // Next index and the bits it selects; bits fall to zero once the stream ends.
   always_comb begin
      idx_d   = idx_q;
      a_bit_d = 1'b0;
      b_bit_d = 1'b0;
      if (clr_i) begin
         idx_d = {IW{1'b0}};
      end else if (step_i) begin
         idx_d = idx_q + IW'(1);
      end else begin
         idx_d = idx_q;
      end
      if (clr_i || step_i) begin
         a_bit_d = (idx_d < a_lat_i);
         b_bit_d = (idx_d < b_lat_i);
      end else begin
         a_bit_d = 1'b0;
         b_bit_d = 1'b0;
      end
   end

   // Index and stream bit registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q   <= {IW{1'b0}};
         a_bit_q <= 1'b0;
         b_bit_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         a_bit_q <= a_bit_d;
         b_bit_q <= b_bit_d;
      end
   end

   assign a_bit_o = a_bit_q;
   assign b_bit_o = b_bit_q;
   assign last_o  = (idx_q == IW'(N - 1));

endmodule

// File: rtl/unary_add_seq_ctrl.sv
// Sequencer for one unary-add datapath: clear, ones-first load, serial write-out,
// then returns the popcount of dp_dout and a sticky carry over a valid/ack handshake.
module unary_add_seq_ctrl
   import unary_add_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int OUT_LEN = 2 * N,
   parameter int DP_LAT  = DP_LAT_DEF,
   parameter int IW      = $clog2(N + 1),
   parameter int RW      = $clog2(OUT_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [IW-1:0] a_val,
   input  logic [IW-1:0] b_val,
   output logic          ready,
   output logic          res_valid,
   input  logic          res_ack,
   output logic [RW-1:0] result,
   output logic          carry,
   output logic          dp_rst_n,
   output logic          dp_en,
   output logic          dp_rw,
   output logic          dp_A,
   output logic          dp_B,
   input  logic          dp_dout,
   input  logic          dp_C
);

   localparam int WLEN = DP_LAT + OUT_LEN;
   localparam int WW   = $clog2(WLEN);

   state_e        state_q, state_d;
   logic [IW-1:0] a_lat_q, b_lat_q;
   logic [RW-1:0] cnt_q;
   logic [RW-1:0] result_q;
   logic [WW-1:0] wcnt_q;
   logic          carry_q;
   logic          res_valid_q;
   logic          dp_rst_n_q, dp_en_q, dp_rw_q;
   logic          gen_clr_s, gen_step_s, gen_last_s;

   unary_stream_gen #(
      .N  (N),
      .IW (IW)
   ) u_stream_gen (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (gen_clr_s),
      .step_i  (gen_step_s),
      .a_lat_i (a_lat_q),
      .b_lat_i (b_lat_q),
      .a_bit_o (dp_A),
      .b_bit_o (dp_B),
      .last_o  (gen_last_s)
   );

   // Phase sequencing; the stream generator is primed in CLEAR and stepped through LOAD.
   always_comb begin
      state_d    = state_q;
      gen_clr_s  = 1'b0;
      gen_step_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            state_d   = LOAD;
            gen_clr_s = 1'b1;
         end
         LOAD: begin
            if (gen_last_s) begin
               state_d = WRITE;
            end else begin
               state_d    = LOAD;
               gen_step_s = 1'b1;
            end
         end
         WRITE: begin
            if (wcnt_q == WW'(WLEN - 1)) begin
               state_d = DONE;
            end else begin
               state_d = WRITE;
            end
         end
         DONE: begin
            if (res_valid_q && res_ack) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath control registers, decoded from the upcoming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         dp_rst_n_q <= 1'b0;
         dp_en_q    <= 1'b0;
         dp_rw_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dp_rst_n_q <= (state_d != CLEAR);
         dp_en_q    <= (state_d == LOAD) || (state_d == WRITE);
         dp_rw_q    <= (state_d == WRITE);
      end
   end

   // Operand latch, ones counter, sticky carry and result handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_lat_q     <= {IW{1'b0}};
         b_lat_q     <= {IW{1'b0}};
         cnt_q       <= {RW{1'b0}};
         wcnt_q      <= {WW{1'b0}};
         carry_q     <= 1'b0;
         res_valid_q <= 1'b0;
         result_q    <= {RW{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_lat_q <= IW'(sat_operand(32'(a_val), N));
                  b_lat_q <= IW'(sat_operand(32'(b_val), N));
                  cnt_q   <= {RW{1'b0}};
                  carry_q <= 1'b0;
               end
            end
            LOAD: begin
               wcnt_q  <= {WW{1'b0}};
               carry_q <= carry_q | dp_C;
            end
            WRITE: begin
               wcnt_q  <= wcnt_q + WW'(1);
               carry_q <= carry_q | dp_C;
               // Samples before DP_LAT belong to the datapath pipeline, not the sum.
               if ((wcnt_q >= WW'(DP_LAT)) && dp_dout && (cnt_q != RW'(OUT_LEN))) begin
                  cnt_q <= cnt_q + RW'(1);
               end
            end
            DONE: begin
               if (!res_valid_q) begin
                  res_valid_q <= 1'b1;
                  result_q    <= cnt_q;
               end else if (res_ack) begin
                  res_valid_q <= 1'b0;
               end
            end
            default: begin
               wcnt_q <= {WW{1'b0}};
            end
         endcase
      end
   end

   assign ready     = (state_q == IDLE);
   assign res_valid = res_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign dp_rst_n  = dp_rst_n_q;
   assign dp_en     = dp_en_q;
   assign dp_rw     = dp_rw_q;

endmodule

// File: tb/tb_unary_add_seq_ctrl.sv
// Bench for unary_add_seq_ctrl: behavioural datapath model, table vectors,
// random operands and hand-written sequences for busy start, reset and held results.
module tb_unary_add_seq_ctrl;

   localparam int N       = 16;
   localparam int OUT_LEN = 32;
   localparam int IW      = 5;
   localparam int RW      = 6;
   localparam int LAT_EXP = 51;

   logic          clk = 1'b0;
   logic          rst;
   logic          start = 1'b0;
   logic [IW-1:0] a_val = '0;
   logic [IW-1:0] b_val = '0;
   logic          res_ack = 1'b0;
   logic          ready, res_valid, carry;
   logic [RW-1:0] result;
   logic          dp_rst_n, dp_en, dp_rw, dp_A, dp_B;
   logic          dp_dout = 1'b0;
   logic          dp_C = 1'b0;

   int total = 0;
   int bad   = 0;

   unary_add_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a_val     (a_val),
      .b_val     (b_val),
      .ready     (ready),
      .res_valid (res_valid),
      .res_ack   (res_ack),
      .result    (result),
      .carry     (carry),
      .dp_rst_n  (dp_rst_n),
      .dp_en     (dp_en),
      .dp_rw     (dp_rw),
      .dp_A      (dp_A),
      .dp_B      (dp_B),
      .dp_dout   (dp_dout),
      .dp_C      (dp_C)
   );

   always #5 clk = ~clk;

   // Datapath model: total ones accumulated in read, emitted ones-first one cycle late.
   int acc = 0;
   int wk  = 0;
   always @(posedge clk) begin
      if (!dp_rst_n) begin
         acc <= 0; wk <= 0; dp_dout <= 1'b0;
      end else if (dp_en && !dp_rw) begin
         acc <= acc + int'(dp_A) + int'(dp_B); wk <= 0; dp_dout <= 1'b0;
      end else if (dp_en && dp_rw) begin
         dp_dout <= (wk < acc); wk <= wk + 1;
      end else begin
         wk <= 0; dp_dout <= 1'b0;
      end
   end

   // Stream monitor: ones per operand, load length, ones-first order, stray bits.
   int tot_a = 0, tot_b = 0, load_cyc = 0, ord_err = 0, stray = 0;
   bit zero_a = 1'b0, zero_b = 1'b0;
   always @(posedge clk) begin
      if (dp_en && !dp_rw) begin
         load_cyc <= load_cyc + 1;
         if (dp_A) tot_a <= tot_a + 1;
         if (dp_B) tot_b <= tot_b + 1;
         if ((dp_A && zero_a) || (dp_B && zero_b)) ord_err <= ord_err + 1;
         zero_a <= zero_a | !dp_A;
         zero_b <= zero_b | !dp_B;
      end else begin
         zero_a <= 1'b0;
         zero_b <= 1'b0;
         if (dp_A || dp_B) stray <= stray + 1;
      end
   end

   int d_a, d_b, d_load, d_ord;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > N) ? N : v;
   endfunction

   // One full transaction; cp = edge carrying a dp_C pulse, bs = edge carrying a busy start.
   task automatic run_op(input int a, input int b, input int cp, input int bs, input bit do_ack,
                         output int res, output int car, output int lat);
      int a0, b0, l0, o0;
      @(negedge clk);
      a0 = tot_a; b0 = tot_b; l0 = load_cyc; o0 = ord_err;
      chk("ready_idle", int'(ready), 1);
      start = 1'b1; a_val = IW'(a); b_val = IW'(b); dp_C = (cp == 0);
      @(posedge clk);
      lat = -1;
      for (int r = 0; r < 200; r++) begin
         @(negedge clk);
         if (res_valid) begin
            lat = r;
            break;
         end
         start = (r + 1 == bs);
         a_val = IW'($urandom);
         b_val = IW'($urandom);
         dp_C  = (r + 1 == cp);
         @(posedge clk);
      end
      start = 1'b0; dp_C = 1'b0;
      res = int'(result); car = int'(carry);
      d_a = tot_a - a0; d_b = tot_b - b0; d_load = load_cyc - l0; d_ord = ord_err - o0;
      if (do_ack) begin
         res_ack = 1'b1;
         @(posedge clk);
         @(negedge clk);
         res_ack = 1'b0;
         chk("ack_valid_drop", int'(res_valid), 0);
         chk("ack_ready", int'(ready), 1);
      end
   endtask

   typedef struct {
      int a;
      int b;
      int cp;
      int exp_res;
      int exp_car;
   } vec_t;

   vec_t vt[8];

   initial begin
      int res, car, lat, ra, rb;
      vt[0] = '{3, 5, -1, 8, 0};
      vt[1] = '{0, 0, -1, 0, 0};
      vt[2] = '{16, 16, -1, 32, 0};
      vt[3] = '{20, 2, -1, 18, 0};
      vt[4] = '{7, 9, 1, 16, 0};
      vt[5] = '{4, 4, 2, 8, 1};
      vt[6] = '{10, 1, 50, 11, 1};
      vt[7] = '{5, 5, 51, 10, 0};

      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_ready", int'(ready), 1);
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_carry", int'(carry), 0);
      chk("rst_dp_rst_n", int'(dp_rst_n), 0);
      chk("rst_dp_en", int'(dp_en), 0);
      chk("rst_dp_ab", int'(dp_A | dp_B | dp_rw), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("idle_dp_rst_n", int'(dp_rst_n), 1);

      foreach (vt[i]) begin
         run_op(vt[i].a, vt[i].b, vt[i].cp, -1, 1'b1, res, car, lat);
         chk($sformatf("vec%0d_result", i), res, vt[i].exp_res);
         chk($sformatf("vec%0d_carry", i), car, vt[i].exp_car);
         chk($sformatf("vec%0d_latency", i), lat, LAT_EXP);
         chk($sformatf("vec%0d_ones_a", i), d_a, sat(vt[i].a));
         chk($sformatf("vec%0d_ones_b", i), d_b, sat(vt[i].b));
         chk($sformatf("vec%0d_load_len", i), d_load, N);
         chk($sformatf("vec%0d_order", i), d_ord, 0);
      end

      for (int k = 0; k < 6; k++) begin
         ra = int'($urandom_range(0, 31));
         rb = int'($urandom_range(0, 31));
         run_op(ra, rb, -1, -1, 1'b1, res, car, lat);
         chk($sformatf("rnd%0d_result a=%0d b=%0d", k, ra, rb), res,
             (sat(ra) + sat(rb) > OUT_LEN) ? OUT_LEN : sat(ra) + sat(rb));
         chk($sformatf("rnd%0d_latency", k), lat, LAT_EXP);
      end

      // start during LOAD with different operands must not disturb the latched pair
      run_op(3, 5, -1, 5, 1'b1, res, car, lat);
      chk("busy_start_result", res, 8);
      chk("busy_start_ones_a", d_a, 3);
      chk("busy_start_latency", lat, LAT_EXP);

      // result held while res_ack stays low, then ack with a simultaneous start
      run_op(6, 7, -1, -1, 1'b0, res, car, lat);
      chk("hold_result0", res, 13);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("hold%0d_result", k), int'(result), 13);
         chk($sformatf("hold%0d_valid", k), int'(res_valid), 1);
         chk($sformatf("hold%0d_ready", k), int'(ready), 0);
      end
      res_ack = 1'b1; start = 1'b1; a_val = IW'(1); b_val = IW'(1);
      @(posedge clk);
      @(negedge clk);
      res_ack = 1'b0; start = 1'b0;
      chk("ack_start_valid", int'(res_valid), 0);
      chk("ack_start_ready", int'(ready), 1);
      @(posedge clk);
      @(negedge clk);
      chk("ack_start_ignored", int'(ready), 1);

      // reset in the middle of WRITE
      start = 1'b1; a_val = IW'(9); b_val = IW'(9);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int r = 1; r <= 30; r++) begin
         dp_C = (r == 5);
         @(posedge clk);
         @(negedge clk);
      end
      dp_C = 1'b0;
      chk("pre_rst_carry", int'(carry), 1);
      chk("pre_rst_in_write", int'(dp_rw), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", int'(ready), 1);
      chk("mid_rst_valid", int'(res_valid), 0);
      chk("mid_rst_result", int'(result), 0);
      chk("mid_rst_carry", int'(carry), 0);
      chk("mid_rst_dp_rst_n", int'(dp_rst_n), 0);
      chk("mid_rst_dp_en", int'(dp_en), 0);
      chk("mid_rst_dp_rw", int'(dp_rw), 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("rst_hold%0d_dp_rst_n", k), int'(dp_rst_n), 0);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_dp_rst_n", int'(dp_rst_n), 1);
      run_op(1, 1, -1, -1, 1'b1, res, car, lat);
      chk("post_rst_result", res, 2);
      chk("post_rst_latency", lat, LAT_EXP);

      chk("stray_stream_bits", stray, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
